// File: rtl/ucode_sequencer_pkg.sv
// ucode_sequencer_pkg: shared types and constants for the per-thread
// micro-PC sequencer (thread/micro-PC widths, context record, commit actions).
package ucode_sequencer_pkg;

    localparam int NTHREAD = 64;
    localparam int TIDMSB  = 5;
    localparam int NUPCMSB = 4;

    typedef logic [TIDMSB:0]  tid_t;
    typedef logic [NUPCMSB:0] upc_t;

    // Per-thread sequencer context.
    typedef struct packed {
        bit             active;
        bit [NUPCMSB:0] upc;
    } ucode_seq_ctx_type;

    localparam upc_t UPC_LAST = 5'd31;
    localparam upc_t UPC_TRAP = 5'd0;

    // What a commit does to the committing thread's context.
    typedef enum logic [2:0] {
        ACT_NONE,     // no commit, or inactive thread without start
        ACT_FLUSH,    // kill the sequence, keep upc
        ACT_REPLAY,   // instruction will be re-executed: hold
        ACT_RESTART,  // start while already active: error, reload
        ACT_START,    // normal sequence entry
        ACT_END,      // uend: sequence finished
        ACT_ADV,      // step to next micro-instruction
        ACT_OVF       // step past UPC_LAST: error, terminate
    } cmt_act_e;

    // Priority decode of the commit port against the current context.
    function automatic cmt_act_e cmt_decode(
        input logic              valid,
        input logic              flush,
        input logic              replay,
        input logic              start,
        input logic              uend,
        input ucode_seq_ctx_type ctx
    );
        cmt_act_e act;
        if (!valid)                act = ACT_NONE;
        else if (flush)            act = ACT_FLUSH;
        else if (replay)           act = ACT_REPLAY;
        else if (start)            act = ctx.active ? ACT_RESTART : ACT_START;
        else if (!ctx.active)      act = ACT_NONE;
        else if (uend)             act = ACT_END;
        else if (ctx.upc == UPC_LAST) act = ACT_OVF;
        else                       act = ACT_ADV;
        return act;
    endfunction

endpackage

// File: rtl/ucode_sequencer_ctx_ram.sv
// ucode_ctx_ram: NTHREAD x context store, one synchronous write port and one
// asynchronous read port, mapped to distributed RAM. A per-entry valid vector
// provides the reset-to-zero view without clearing the array itself.
module ucode_ctx_ram
    import ucode_sequencer_pkg::*;
(
    input  logic              gclk,
    input  logic              rst,
    input  logic              we,
    input  tid_t              waddr,
    input  ucode_seq_ctx_type wdata,
    input  tid_t              raddr,
    output ucode_seq_ctx_type rdata
);

    ucode_seq_ctx_type        ctx_mem [NTHREAD];
    logic [NTHREAD-1:0]       vld_q;
    logic [NTHREAD-1:0]       vld_d;

    // Storage array write port.
    // NOTE: the array has no reset so it stays a plain LUT RAM; entries not
    // written since reset are masked to zero through vld_q instead.
    always_ff @(posedge gclk) begin
        if (we) ctx_mem[waddr] <= wdata;
    end

    // Next valid vector: an entry becomes meaningful once written.
    always_comb begin
        vld_d = vld_q;
        if (we) vld_d[waddr] = 1'b1;
    end

    // Valid vector register, cleared by reset.
    always_ff @(posedge gclk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    // Asynchronous read, zero context for never-written entries.
    always_comb begin
        rdata = vld_q[raddr] ? ctx_mem[raddr] : '0;
    end

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: per-thread micro-PC sequencer. Issue port presents the
// registered micro-ROM address of the issuing thread; commit port advances,
// holds or terminates the committing thread's sequence.
// Optional statistics counters (stat_useq, stat_ucyc) with UCODE_SEQ_STAT_EN.
module ucode_sequencer
    import ucode_sequencer_pkg::*;
(
    input  logic              gclk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [TIDMSB:0]   iss_tid,
    output logic              uc_valid,
    output logic [TIDMSB:0]   uc_tid,
    output logic [NUPCMSB:0]  uc_addr,
    input  logic              cmt_valid,
    input  logic [TIDMSB:0]   cmt_tid,
    input  logic              cmt_start,
    input  logic [NUPCMSB:0]  cmt_start_upc,
    input  logic              cmt_uend,
    input  logic              cmt_replay,
    input  logic              cmt_flush,
`ifdef UCODE_SEQ_STAT_EN
    output logic [31:0]       stat_useq,
    output logic [31:0]       stat_ucyc,
`endif
    output logic              ucode_err
);

    ucode_seq_ctx_type cmt_ctx;
    ucode_seq_ctx_type iss_rd_ctx;
    ucode_seq_ctx_type iss_ctx;
    ucode_seq_ctx_type new_ctx;
    cmt_act_e          cmt_act;
    logic              err_set;
    logic              ctx_we;

    logic              uc_valid_q,  uc_valid_d;
    tid_t              uc_tid_q,    uc_tid_d;
    upc_t              uc_addr_q,   uc_addr_d;
    logic              ucode_err_q, ucode_err_d;

    // The context store is replicated so commit and issue each get their own
    // asynchronous read port; both copies see identical writes.
    ucode_ctx_ram u_cmt_ram (
        .gclk  (gclk),
        .rst   (rst),
        .we    (ctx_we),
        .waddr (cmt_tid),
        .wdata (new_ctx),
        .raddr (cmt_tid),
        .rdata (cmt_ctx)
    );

    ucode_ctx_ram u_iss_ram (
        .gclk  (gclk),
        .rst   (rst),
        .we    (ctx_we),
        .waddr (cmt_tid),
        .wdata (new_ctx),
        .raddr (iss_tid),
        .rdata (iss_rd_ctx)
    );

    // Commit update: prioritised action on the committing thread's context.
    // NOTE: every variable written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        cmt_act = cmt_decode(cmt_valid, cmt_flush, cmt_replay, cmt_start,
                             cmt_uend, cmt_ctx);
        new_ctx = cmt_ctx;
        err_set = 1'b0;
        unique case (cmt_act)
            ACT_FLUSH:   new_ctx.active = 1'b0;
            ACT_RESTART: begin
                err_set        = 1'b1;
                new_ctx.active = 1'b1;
                new_ctx.upc    = cmt_start_upc;
            end
            ACT_START: begin
                new_ctx.active = 1'b1;
                new_ctx.upc    = cmt_start_upc;
            end
            ACT_END:     new_ctx.active = 1'b0;
            ACT_ADV:     new_ctx.upc    = cmt_ctx.upc + upc_t'(1);
            ACT_OVF: begin
                err_set        = 1'b1;
                new_ctx.active = 1'b0;
                new_ctx.upc    = '0;
            end
            default: ;
        endcase
        ctx_we = cmt_valid && !rst;
    end

    // Issue read with write-first bypass from a same-thread commit.
    always_comb begin
        iss_ctx = (cmt_valid && (cmt_tid == iss_tid)) ? new_ctx : iss_rd_ctx;
        uc_valid_d  = iss_valid && iss_ctx.active;
        uc_tid_d    = iss_valid ? iss_tid     : uc_tid_q;
        uc_addr_d   = iss_valid ? iss_ctx.upc : uc_addr_q;
        ucode_err_d = ucode_err_q || err_set;
    end

    // Output registers; synchronous reset overrides any in-flight update.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge gclk) begin
        if (rst) begin
            uc_valid_q  <= 1'b0;
            uc_tid_q    <= '0;
            uc_addr_q   <= '0;
            ucode_err_q <= 1'b0;
        end else begin
            uc_valid_q  <= uc_valid_d;
            uc_tid_q    <= uc_tid_d;
            uc_addr_q   <= uc_addr_d;
            ucode_err_q <= ucode_err_d;
        end
    end

    assign uc_valid  = uc_valid_q;
    assign uc_tid    = uc_tid_q;
    assign uc_addr   = uc_addr_q;
    assign ucode_err = ucode_err_q;

`ifdef UCODE_SEQ_STAT_EN
    logic [31:0] stat_useq_q, stat_useq_d;
    logic [31:0] stat_ucyc_q, stat_ucyc_d;

    // Statistics: sequence starts and active-thread commits, wrapping.
    always_comb begin
        stat_useq_d = stat_useq_q;
        stat_ucyc_d = stat_ucyc_q;
        if (cmt_act == ACT_START || cmt_act == ACT_RESTART)
            stat_useq_d = stat_useq_q + 32'd1;
        if (cmt_act == ACT_RESTART || cmt_act == ACT_END ||
            cmt_act == ACT_ADV     || cmt_act == ACT_OVF)
            stat_ucyc_d = stat_ucyc_q + 32'd1;
    end

    // Statistics registers.
    always_ff @(posedge gclk) begin
        if (rst) begin
            stat_useq_q <= '0;
            stat_ucyc_q <= '0;
        end else begin
            stat_useq_q <= stat_useq_d;
            stat_ucyc_q <= stat_ucyc_d;
        end
    end

    assign stat_useq = stat_useq_q;
    assign stat_ucyc = stat_ucyc_q;
`endif

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: table-driven bench with an expected-value queue for
// ucode_sequencer. Statistics checks are compiled with UCODE_SEQ_STAT_EN.
module tb_ucode_sequencer;

    logic       gclk = 1'b0;
    logic       rst;
    logic       iss_valid;
    logic [5:0] iss_tid;
    logic       uc_valid;
    logic [5:0] uc_tid;
    logic [4:0] uc_addr;
    logic       cmt_valid;
    logic [5:0] cmt_tid;
    logic       cmt_start;
    logic [4:0] cmt_start_upc;
    logic       cmt_uend;
    logic       cmt_replay;
    logic       cmt_flush;
    logic       ucode_err;
`ifdef UCODE_SEQ_STAT_EN
    logic [31:0] stat_useq;
    logic [31:0] stat_ucyc;
`endif

    ucode_sequencer dut (
        .gclk          (gclk),
        .rst           (rst),
        .iss_valid     (iss_valid),
        .iss_tid       (iss_tid),
        .uc_valid      (uc_valid),
        .uc_tid        (uc_tid),
        .uc_addr       (uc_addr),
        .cmt_valid     (cmt_valid),
        .cmt_tid       (cmt_tid),
        .cmt_start     (cmt_start),
        .cmt_start_upc (cmt_start_upc),
        .cmt_uend      (cmt_uend),
        .cmt_replay    (cmt_replay),
        .cmt_flush     (cmt_flush),
`ifdef UCODE_SEQ_STAT_EN
        .stat_useq     (stat_useq),
        .stat_ucyc     (stat_ucyc),
`endif
        .ucode_err     (ucode_err)
    );

    always #5 gclk = ~gclk;

    typedef struct {
        logic       iss_v;
        logic [5:0] iss_tid;
        logic       cmt_v;
        logic [5:0] cmt_tid;
        logic       start;
        logic [4:0] supc;
        logic       uend;
        logic       replay;
        logic       flush;
        logic       e_ucv;
        logic [5:0] e_tid;
        logic [4:0] e_addr;
        logic       e_err;
    } vec_t;

    typedef struct {
        logic       ucv;
        logic [5:0] tid;
        logic [4:0] addr;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[28];

    function automatic vec_t mk(
        input logic iv, input int it,
        input logic cv, input int ct, input logic st, input int su,
        input logic ue, input logic rp, input logic fl,
        input logic eucv, input int etid, input int eaddr, input logic eerr);
        vec_t v;
        v.iss_v = iv;  v.iss_tid = 6'(it);
        v.cmt_v = cv;  v.cmt_tid = 6'(ct); v.start = st; v.supc = 5'(su);
        v.uend = ue;   v.replay = rp;      v.flush = fl;
        v.e_ucv = eucv; v.e_tid = 6'(etid); v.e_addr = 5'(eaddr); v.e_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        iss_valid = 1'b0; iss_tid = '0;
        cmt_valid = 1'b0; cmt_tid = '0; cmt_start = 1'b0; cmt_start_upc = '0;
        cmt_uend = 1'b0;  cmt_replay = 1'b0; cmt_flush = 1'b0;
    endtask

    // Drive one vector for one cycle, queue its expectation, compare after
    // the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        iss_valid = v.iss_v; iss_tid = v.iss_tid;
        cmt_valid = v.cmt_v; cmt_tid = v.cmt_tid; cmt_start = v.start;
        cmt_start_upc = v.supc; cmt_uend = v.uend; cmt_replay = v.replay;
        cmt_flush = v.flush;
        e.ucv = v.e_ucv; e.tid = v.e_tid; e.addr = v.e_addr; e.err = v.e_err;
        exp_q.push_back(e);
        @(posedge gclk);
        #1;
        got = exp_q.pop_front();
        check({tag, ".uc_valid"},  32'(uc_valid),  32'(got.ucv));
        if (got.ucv || v.iss_v)
            check({tag, ".uc_tid"}, 32'(uc_tid), 32'(got.tid));
        check({tag, ".uc_addr"},   32'(uc_addr),   32'(got.addr));
        check({tag, ".ucode_err"}, 32'(ucode_err), 32'(got.err));
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge gclk);
        #1;
        rst = 1'b0;
        check("rst.uc_valid",  32'(uc_valid),  32'd0);
        check("rst.uc_tid",    32'(uc_tid),    32'd0);
        check("rst.uc_addr",   32'(uc_addr),   32'd0);
        check("rst.ucode_err", 32'(ucode_err), 32'd0);
`ifdef UCODE_SEQ_STAT_EN
        check("rst.stat_useq", stat_useq, 32'd0);
        check("rst.stat_ucyc", stat_ucyc, 32'd0);
`endif
    endtask

    initial begin
        //                iv it  cv ct st su ue rp fl  ucv tid adr err
        vecs[0]  = mk(1, 3,  0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0);  // idle thread
        vecs[1]  = mk(0, 0,  1, 3, 1, 7, 0, 0, 0,  0, 3, 0, 0);  // start tid3@7
        vecs[2]  = mk(1, 3,  0, 0, 0, 0, 0, 0, 0,  1, 3, 7, 0);
        vecs[3]  = mk(0, 0,  1, 3, 0, 0, 0, 0, 0,  0, 3, 7, 0);  // advance
        vecs[4]  = mk(1, 3,  0, 0, 0, 0, 0, 0, 0,  1, 3, 8, 0);
        vecs[5]  = mk(0, 0,  1, 3, 0, 0, 1, 0, 0,  0, 3, 8, 0);  // uend
        vecs[6]  = mk(1, 3,  0, 0, 0, 0, 0, 0, 0,  0, 3, 8, 0);
        vecs[7]  = mk(0, 0,  1, 5, 1, 9, 0, 0, 0,  0, 3, 8, 0);  // start tid5@9
        vecs[8]  = mk(0, 0,  1, 5, 0, 0, 1, 1, 0,  0, 3, 8, 0);  // replay beats uend
        vecs[9]  = mk(1, 5,  0, 0, 0, 0, 0, 0, 0,  1, 5, 9, 0);
        vecs[10] = mk(0, 0,  1, 5, 1, 2, 0, 0, 1,  0, 5, 9, 0);  // flush beats start
        vecs[11] = mk(1, 5,  0, 0, 0, 0, 0, 0, 0,  0, 5, 9, 0);
        vecs[12] = mk(1, 10, 1, 10, 1, 0, 0, 0, 0, 1, 10, 0, 0); // bypass start
        vecs[13] = mk(1, 10, 0, 0, 0, 0, 0, 0, 0,  1, 10, 0, 0);
        vecs[14] = mk(1, 10, 1, 10, 0, 0, 0, 0, 0, 1, 10, 1, 0); // bypass advance
        vecs[15] = mk(1, 10, 0, 10, 1, 3, 0, 0, 1, 1, 10, 1, 0); // cmt_valid=0
        vecs[16] = mk(0, 0,  1, 1, 1, 31, 0, 0, 0, 0, 10, 1, 0); // start tid1@31
        vecs[17] = mk(1, 1,  0, 0, 0, 0, 0, 0, 0,  1, 1, 31, 0);
        vecs[18] = mk(0, 0,  1, 1, 0, 0, 0, 0, 0,  0, 1, 31, 1); // overflow
        vecs[19] = mk(1, 1,  0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
        vecs[20] = mk(0, 0,  1, 0, 1, 4, 0, 0, 0,  0, 1, 0, 1);  // start tid0@4
        vecs[21] = mk(0, 0,  1, 63, 1, 14, 0, 0, 0, 0, 1, 0, 1); // start tid63@14
        vecs[22] = mk(0, 0,  1, 0, 0, 0, 0, 0, 0,  0, 1, 0, 1);
        vecs[23] = mk(1, 63, 0, 0, 0, 0, 0, 0, 0,  1, 63, 14, 1);
        vecs[24] = mk(1, 0,  1, 63, 0, 0, 0, 0, 0, 1, 0, 5, 1);
        vecs[25] = mk(1, 63, 0, 0, 0, 0, 0, 0, 0,  1, 63, 15, 1);
        vecs[26] = mk(1, 63, 1, 0, 0, 0, 1, 0, 0,  1, 63, 15, 1);
        vecs[27] = mk(1, 0,  0, 0, 0, 0, 0, 0, 0,  0, 0, 5, 1);

        do_reset();
        for (int i = 0; i < 28; i++) apply(vecs[i], $sformatf("v%0d", i));
`ifdef UCODE_SEQ_STAT_EN
        check("tbl.stat_useq", stat_useq, 32'd6);
        check("tbl.stat_ucyc", stat_ucyc, 32'd7);
`endif

        // Mid-sequence reset: tid10 and tid63 were active, error was set.
        do_reset();
        apply(mk(1, 10, 0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0), "post_rst.t10");
        apply(mk(1, 63, 0, 0, 0, 0, 0, 0, 0, 0, 63, 0, 0), "post_rst.t63");
        // uend on an inactive thread is ignored.
        apply(mk(0, 0, 1, 30, 0, 0, 1, 0, 0, 0, 63, 0, 0), "idle_uend");
        apply(mk(1, 30, 0, 0, 0, 0, 0, 0, 0, 0, 30, 0, 0), "idle_uend.iss");
        // Nested start: error, sequence restarts at the new entry.
        apply(mk(0, 0, 1, 20, 1, 2, 0, 0, 0, 0, 30, 0, 0), "nest.start");
        apply(mk(0, 0, 1, 20, 1, 6, 0, 0, 0, 0, 30, 0, 1), "nest.restart");
        apply(mk(1, 20, 0, 0, 0, 0, 0, 0, 0, 1, 20, 6, 1), "nest.iss");
`ifdef UCODE_SEQ_STAT_EN
        check("nest.stat_useq", stat_useq, 32'd2);
        check("nest.stat_ucyc", stat_ucyc, 32'd1);
`endif
        if (exp_q.size() != 0) check("sb.drain", 32'(exp_q.size()), 32'd0);

        idle_inputs();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
